// File: rtl/axis_pkt_pkg.sv
// Shared definitions for the AXI4-Stream packetizer.
//   state_e      : packetizer FSM states
//   SEQ_* / LEN_*: bit positions of the header word fields
//   make_header  : packs {sequence number, payload length} into one 32-bit word
package axis_pkt_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    PAYLOAD = 2'd2
  } state_e;

  localparam int SEQ_MSB = 31;
  localparam int SEQ_LSB = 16;
  localparam int LEN_MSB = 15;
  localparam int LEN_LSB = 0;

  function automatic logic [31:0] make_header(input logic [15:0] seq,
                                              input logic [15:0] len);
    logic [31:0] word;
    word                  = '0;
    word[SEQ_MSB:SEQ_LSB] = seq;
    word[LEN_MSB:LEN_LSB] = len;
    return word;
  endfunction

endpackage

// File: rtl/axis_stream_packetizer_if.sv
// AXI4-Stream bundle used on both sides of the packetizer.
//   tvalid/tready : handshake
//   tdata         : DATA_W-bit word
//   tlast         : end of packet
//   tkeep         : byte enables
// master drives the payload signals and samples tready; slave is the mirror.
interface axis_stream_packetizer_if #(
  parameter int DATA_W = 32
) ();

  logic                tvalid;
  logic                tready;
  logic [DATA_W-1:0]   tdata;
  logic                tlast;
  logic [DATA_W/8-1:0] tkeep;

  modport master (output tvalid, tdata, tlast, tkeep, input tready);
  modport slave  (input tvalid, tdata, tlast, tkeep, output tready);

endinterface

// File: rtl/axis_skid_buffer.sv
// Two-entry output buffer with registered outputs.
//   aclk, aresetn : clock, synchronous active-low reset
//   in_valid_i    : write request; accepted when not full, or when full and popping
//   in_data_i     : word to store
//   full_o        : both entries occupied (registered)
//   out_valid_o   : head entry valid (registered)
//   out_data_o    : head entry (registered)
//   out_ready_i   : downstream accepts the head entry
module axis_skid_buffer #(
  parameter int WIDTH = 33
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             full_o,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] out_data_o,
  input  logic             out_ready_i
);

  logic [1:0]       count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic             pop, push;

  assign pop  = (count_q != 2'd0) && out_ready_i;
  assign push = in_valid_i && ((count_q != 2'd2) || pop);

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    unique case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) head_d = in_data_i;
        else                 tail_d = in_data_i;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        // Occupancy unchanged: the new word lands behind whatever is still queued.
        if (count_q == 2'd1) begin
          head_d = in_data_i;
        end else begin
          head_d = tail_q;
          tail_d = in_data_i;
        end
      end
      default: ;
    endcase
  end

  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      count_q <= 2'd0;
      head_q  <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
    end
  end

  // NOTE: the tail entry is storage, not control; occupancy gates it, so it needs no reset.
  always_ff @(posedge aclk) begin
    tail_q <= tail_d;
  end

  assign full_o      = (count_q == 2'd2);
  assign out_valid_o = (count_q != 2'd0);
  assign out_data_o  = head_q;

endmodule

// File: rtl/axis_stream_packetizer.sv
// Slices an endless AXI4-Stream into fixed-length packets with TLAST on the
// final word, optionally preceded by a {seq[15:0], len[15:0]} header word.
//   aclk, aresetn : clock, synchronous active-low reset
//   enable        : start/continue packetizing, sampled at packet boundaries
//   pkt_len       : payload words per packet (0 treated as 1), latched per packet
//   s_axis        : upstream stream (tlast/tkeep ignored)
//   m_axis        : packetized output, registered through a 2-entry buffer
//   pkt_count     : packets completed since reset, wraps
//   busy          : FSM active or output buffer non-empty
module axis_stream_packetizer
  import axis_pkt_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int LEN_W     = 16,
  parameter int HEADER_EN = 1
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     enable,
  input  logic [LEN_W-1:0]         pkt_len,
  axis_stream_packetizer_if.slave  s_axis,
  axis_stream_packetizer_if.master m_axis,
  output logic [31:0]              pkt_count,
  output logic                     busy
);

  state_e           state_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] word_cnt_q;
  logic [15:0]      seq_q;
  logic [31:0]      pkt_count_q;

  logic             buf_full, buf_valid;
  logic             push_valid;
  logic [DATA_W:0]  push_data;
  logic [DATA_W:0]  buf_out;
  logic             in_hs, last_word;
  logic [LEN_W-1:0] eff_len;

  logic unused_inputs;
  assign unused_inputs = &{1'b0, s_axis.tlast, s_axis.tkeep};

  assign eff_len   = (pkt_len == '0) ? LEN_W'(1) : pkt_len;
  assign s_axis.tready = (state_q == PAYLOAD) && !buf_full;
  assign in_hs     = s_axis.tvalid && s_axis.tready;
  assign last_word = (word_cnt_q == len_q - LEN_W'(1));

  always_comb begin
    push_valid = 1'b0;
    push_data  = '0;
    unique case (state_q)
      HEADER: begin
        push_valid = !buf_full;
        push_data  = {1'b0, DATA_W'(make_header(seq_q, 16'(len_q)))};
      end
      PAYLOAD: begin
        push_valid = in_hs;
        push_data  = {last_word, s_axis.tdata};
      end
      default: ;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q     <= IDLE;
      len_q       <= LEN_W'(1);
      word_cnt_q  <= '0;
      seq_q       <= '0;
      pkt_count_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (enable) begin
            len_q      <= eff_len;
            word_cnt_q <= '0;
            state_q    <= (HEADER_EN != 0) ? HEADER : PAYLOAD;
          end
        end
        HEADER: begin
          if (!buf_full) state_q <= PAYLOAD;
        end
        PAYLOAD: begin
          if (in_hs) begin
            if (last_word) begin
              seq_q       <= seq_q + 16'd1;
              pkt_count_q <= pkt_count_q + 32'd1;
              word_cnt_q  <= '0;
              // enable only matters here, on the packet boundary.
              if (enable) begin
                len_q   <= eff_len;
                state_q <= (HEADER_EN != 0) ? HEADER : PAYLOAD;
              end else begin
                state_q <= IDLE;
              end
            end else begin
              word_cnt_q <= word_cnt_q + LEN_W'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  axis_skid_buffer #(.WIDTH(DATA_W + 1)) u_skid (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .in_valid_i  (push_valid),
    .in_data_i   (push_data),
    .full_o      (buf_full),
    .out_valid_o (buf_valid),
    .out_data_o  (buf_out),
    .out_ready_i (m_axis.tready)
  );

  assign m_axis.tvalid = buf_valid;
  assign m_axis.tdata  = buf_out[DATA_W-1:0];
  assign m_axis.tlast  = buf_out[DATA_W];
  assign m_axis.tkeep  = '1;

  assign pkt_count = pkt_count_q;
  assign busy      = (state_q != IDLE) || buf_valid;

endmodule

// File: tb/tb_axis_stream_packetizer.sv
// Bench for axis_stream_packetizer: one instance with headers, one without.
// Expected output words are queued when a scenario's stimulus is planned and
// popped as the selected DUT hands words downstream.
module tb_axis_stream_packetizer;

  logic aclk    = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  axis_stream_packetizer_if #(.DATA_W(32)) s_h ();
  axis_stream_packetizer_if #(.DATA_W(32)) m_h ();
  axis_stream_packetizer_if #(.DATA_W(32)) s_r ();
  axis_stream_packetizer_if #(.DATA_W(32)) m_r ();

  logic        en_h, en_r, busy_h, busy_r;
  logic [15:0] len_h, len_r;
  logic [31:0] cnt_h, cnt_r;

  axis_stream_packetizer #(.DATA_W(32), .LEN_W(16), .HEADER_EN(1)) u_hdr (
    .aclk(aclk), .aresetn(aresetn), .enable(en_h), .pkt_len(len_h),
    .s_axis(s_h), .m_axis(m_h), .pkt_count(cnt_h), .busy(busy_h)
  );

  axis_stream_packetizer #(.DATA_W(32), .LEN_W(16), .HEADER_EN(0)) u_raw (
    .aclk(aclk), .aresetn(aresetn), .enable(en_r), .pkt_len(len_r),
    .s_axis(s_r), .m_axis(m_r), .pkt_count(cnt_r), .busy(busy_r)
  );

  // Bench-side drive values, steered to the selected DUT (0 = header, 1 = raw).
  logic        sel = 1'b0;
  logic        enable_v = 1'b0;
  logic [15:0] pkt_len_v = 16'd0;
  logic        src_valid = 1'b0;
  logic [31:0] src_data = 32'd0;
  logic        m_ready = 1'b1;

  assign en_h = !sel && enable_v;
  assign en_r =  sel && enable_v;
  assign len_h = pkt_len_v;
  assign len_r = pkt_len_v;
  assign s_h.tvalid = !sel && src_valid;
  assign s_r.tvalid =  sel && src_valid;
  assign s_h.tdata = src_data;
  assign s_r.tdata = src_data;
  assign s_h.tlast = 1'b0;
  assign s_r.tlast = 1'b0;
  assign s_h.tkeep = '1;
  assign s_r.tkeep = '1;
  assign m_h.tready = sel ? 1'b1 : m_ready;
  assign m_r.tready = sel ? m_ready : 1'b1;

  logic        o_valid, o_last, i_ready, o_busy;
  logic [31:0] o_data, o_cnt;
  logic [3:0]  o_keep;
  assign o_valid = sel ? m_r.tvalid : m_h.tvalid;
  assign o_last  = sel ? m_r.tlast  : m_h.tlast;
  assign o_data  = sel ? m_r.tdata  : m_h.tdata;
  assign o_keep  = sel ? m_r.tkeep  : m_h.tkeep;
  assign i_ready = sel ? s_r.tready : s_h.tready;
  assign o_busy  = sel ? busy_r : busy_h;
  assign o_cnt   = sel ? cnt_r : cnt_h;

  logic [32:0] exp_q[$];
  logic [31:0] src_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          accepted = 0;
  int          mode     = 0;   // 0 ready high, 1 toggle, 2 random, 3 held low
  bit          auto_drop = 1'b0;
  int          drop_at  = 0;
  bit          stalled_prev = 1'b0;
  logic [32:0] held;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive_src();
    src_valid = (src_q.size() != 0);
    src_data  = src_valid ? src_q[0] : 32'd0;
  endtask

  // One clock: observe handshakes at the falling edge, drive after the rising edge.
  task automatic step();
    logic [32:0] e;
    @(negedge aclk);
    if (stalled_prev) check("stall_hold", {31'd0, o_valid, o_last, o_data}, {31'd1, held});
    if (o_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        check("output_when_none_expected", {63'd0, o_valid}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("out_word", {31'd0, o_last, o_data}, {31'd0, e});
      end
    end
    stalled_prev = o_valid && !m_ready;
    held         = {o_last, o_data};
    if (src_valid && i_ready) begin
      void'(src_q.pop_front());
      accepted++;
    end
    @(posedge aclk);
    #1;
    drive_src();
    case (mode)
      0:       m_ready = 1'b1;
      1:       m_ready = ~m_ready;
      2:       m_ready = 1'($urandom_range(0, 1));
      default: m_ready = 1'b0;
    endcase
    if (auto_drop && accepted >= drop_at) enable_v = 1'b0;
  endtask

  task automatic clear_bench();
    exp_q.delete();
    src_q.delete();
    accepted     = 0;
    stalled_prev = 1'b0;
  endtask

  task automatic do_reset();
    aresetn   = 1'b0;
    enable_v  = 1'b0;
    src_valid = 1'b0;
    src_data  = 32'd0;
    m_ready   = 1'b1;
    auto_drop = 1'b0;
    mode      = 0;
    clear_bench();
    @(posedge aclk);
    #1;
    check("reset_ctrl", {60'd0, o_valid, o_last, i_ready, o_busy}, 64'd0);
    check("reset_data_cnt", {o_data, o_cnt}, 64'd0);
    aresetn = 1'b1;
  endtask

  task automatic run_until_done(input int budget, input string name);
    int c = 0;
    while ((exp_q.size() != 0 || src_q.size() != 0 || o_busy) && c < budget) begin
      step();
      c++;
    end
    check({name, "_drained"}, {63'd0, c < budget}, 64'd1);
  endtask

  task automatic load_src(input logic [31:0] base, input int n);
    for (int k = 0; k < n; k++) src_q.push_back(base + 32'(k));
  endtask

  // Header word layout: sequence number in the upper half, length in the lower half.
  task automatic push_packet(input bit hdr, input int seq, input int eff, input logic [31:0] first);
    if (hdr) exp_q.push_back({1'b0, 16'(seq), 16'(eff)});
    for (int i = 0; i < eff; i++) exp_q.push_back({i == eff - 1, first + 32'(i)});
  endtask

  typedef struct {
    bit raw;
    int len;
    int n;
    int mode;
    int exp_pkts;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{raw: 1'b0, len: 4, n: 8,  mode: 0, exp_pkts: 2};
    vecs[1] = '{raw: 1'b1, len: 3, n: 12, mode: 1, exp_pkts: 4};
    vecs[2] = '{raw: 1'b0, len: 0, n: 3,  mode: 0, exp_pkts: 3};
    vecs[3] = '{raw: 1'b1, len: 1, n: 5,  mode: 2, exp_pkts: 5};
    vecs[4] = '{raw: 1'b0, len: 5, n: 10, mode: 2, exp_pkts: 2};

    for (int r = 0; r < 5; r++) begin
      int          eff;
      logic [31:0] base;
      sel = vecs[r].raw;
      do_reset();
      eff  = (vecs[r].len == 0) ? 1 : vecs[r].len;
      base = 32'(r) << 28;
      mode = vecs[r].mode;
      pkt_len_v = 16'(vecs[r].len);
      load_src(base, vecs[r].n);
      for (int p = 0; p < vecs[r].n / eff; p++)
        push_packet(!vecs[r].raw, p, eff, base + 32'(p * eff));
      auto_drop = 1'b1;
      drop_at   = vecs[r].n - eff;
      enable_v  = 1'b1;
      drive_src();
      run_until_done(2000, $sformatf("row%0d", r));
      check($sformatf("row%0d_pkt_count", r), {32'd0, o_cnt}, 64'(vecs[r].exp_pkts));
      check($sformatf("row%0d_idle", r), {62'd0, i_ready, o_busy}, 64'd0);
      check($sformatf("row%0d_tkeep", r), {60'd0, o_keep}, 64'hF);
    end

    // enable dropped after the 2nd payload word of an 8-word packet.
    sel = 1'b0;
    do_reset();
    pkt_len_v = 16'd8;
    load_src(32'h0000_00C0, 8);
    push_packet(1'b1, 0, 8, 32'h0000_00C0);
    auto_drop = 1'b1;
    drop_at   = 2;
    enable_v  = 1'b1;
    drive_src();
    begin
      int c = 0;
      while (accepted < 8 && c < 500) begin step(); c++; end
      check("t3_all_accepted", 64'(accepted), 64'd8);
    end
    mode    = 3;
    m_ready = 1'b0;
    step();
    // Last word parked in the buffer: FSM idle, output still pending.
    check("t3_parked", {60'd0, o_valid, o_last, i_ready, o_busy}, 64'b1101);
    check("t3_enable_low", {63'd0, enable_v}, 64'd0);
    mode = 0;
    run_until_done(200, "t3");
    check("t3_pkt_count", {32'd0, o_cnt}, 64'd1);
    check("t3_idle", {62'd0, i_ready, o_busy}, 64'd0);

    // pkt_len changed 4 -> 2 during packet 1.
    do_reset();
    pkt_len_v = 16'd4;
    load_src(32'h0000_0050, 6);
    push_packet(1'b1, 0, 4, 32'h0000_0050);
    push_packet(1'b1, 1, 2, 32'h0000_0054);
    auto_drop = 1'b1;
    drop_at   = 4;
    enable_v  = 1'b1;
    drive_src();
    begin
      int c = 0;
      while (accepted < 1 && c < 100) begin step(); c++; end
    end
    pkt_len_v = 16'd2;
    run_until_done(300, "t5");
    check("t5_pkt_count", {32'd0, o_cnt}, 64'd2);

    // Reset mid-packet with the output buffer full.
    do_reset();
    pkt_len_v = 16'd4;
    load_src(32'h0000_0060, 8);
    mode      = 3;
    m_ready   = 1'b0;
    enable_v  = 1'b1;
    drive_src();
    for (int k = 0; k < 5; k++) step();
    check("t6_full_stall", {62'd0, o_valid, i_ready}, 64'b10);
    aresetn = 1'b0;
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    check("t6_after_reset", {31'd0, o_valid, o_cnt}, 64'd0);
    clear_bench();
    load_src(32'h0000_0070, 4);
    push_packet(1'b1, 0, 4, 32'h0000_0070);
    mode      = 0;
    m_ready   = 1'b1;
    auto_drop = 1'b1;
    drop_at   = 0;
    drive_src();
    run_until_done(300, "t6");
    check("t6_pkt_count", {32'd0, o_cnt}, 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
